// File: rtl/detect_pkg.sv
// ============================================================================
//  Module      : detect_pkg
//  Description : Shared constants and state type for the serial detector of
//                the 12-bit pattern 111000000111 (leftmost bit arrives first).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package detect_pkg;

  // Pattern length and the pattern itself, MSB = first bit on the wire
  localparam int                 PAT_LEN = 12;
  localparam logic [PAT_LEN-1:0] PATTERN = 12'b111000000111;

  // Sk = the first k pattern bits have been matched
  typedef enum logic [3:0] {
    S0  = 4'd0,
    S1  = 4'd1,
    S2  = 4'd2,
    S3  = 4'd3,
    S4  = 4'd4,
    S5  = 4'd5,
    S6  = 4'd6,
    S7  = 4'd7,
    S8  = 4'd8,
    S9  = 4'd9,
    S10 = 4'd10,
    S11 = 4'd11,
    S12 = 4'd12
  } state_t;

endpackage

`default_nettype wire

// File: rtl/detect.sv
// ============================================================================
//  Module      : detect
//  Description : Moore FSM that samples one serial bit per clock and raises a
//                one-cycle flag when the last 12 bits equal detect_pkg::PATTERN.
//                Overlapping occurrences are detected (the trailing 111 of a
//                match is reused as the prefix of the next one).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module detect
  import detect_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic x_i,
  output logic det_o
);

  state_t state;
  state_t next_state;

  // State register; reset discards any partial match
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S0;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: each state falls back to the longest pattern prefix
  // that is still a suffix of the bits seen so far
  always_comb begin
    next_state = S0;
    case (state)
      S0:  next_state = x_i ? S1  : S0;
      S1:  next_state = x_i ? S2  : S0;
      S2:  next_state = x_i ? S3  : S0;
      // Extra leading ones keep us at "111 seen"
      S3:  next_state = x_i ? S3  : S4;
      // Inside the zero run a one means only "1" of a new prefix survives
      S4:  next_state = x_i ? S1  : S5;
      S5:  next_state = x_i ? S1  : S6;
      S6:  next_state = x_i ? S1  : S7;
      S7:  next_state = x_i ? S1  : S8;
      S8:  next_state = x_i ? S1  : S9;
      // Seven zeros is one too many; the run can no longer align
      S9:  next_state = x_i ? S10 : S0;
      S10: next_state = x_i ? S11 : S0;
      S11: next_state = x_i ? S12 : S0;
      // Overlap: trailing 111 of the match is the next prefix
      S12: next_state = x_i ? S3  : S4;
      // Encodings 13..15 are unreachable; recover to idle
      default: next_state = S0;
    endcase
  end

  // Moore output decoded from the registered state only
  always_comb begin
    det_o = (state == S12);
  end

endmodule

`default_nettype wire

// File: tb/tb_detect.sv
// ============================================================================
//  Module      : tb_detect
//  Description : Self-checking bench for detect: directed scenarios plus a
//                long random stream, all compared against a bit-history model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_detect;

  logic clk = 1'b0;
  logic rst;
  logic x_i;
  logic det_o;

  always #5 clk = ~clk;

  detect dut (
    .clk   (clk),
    .rst   (rst),
    .x_i   (x_i),
    .det_o (det_o)
  );

  localparam logic [11:0] REF_PAT = 12'b111000000111;

  // Reference model state: last 12 sampled bits and how many are valid since reset
  logic [11:0] hist;
  int          valid;
  logic        exp_det;
  logic        prev_det;

  int n_total;
  int n_pass;
  int cyc;
  int pulses;
  int last_pulse;
  int last_gap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
  endtask

  // One clock: apply inputs, update the model at the edge, check after the edge
  task automatic tick(input logic r, input logic x);
    rst = r;
    x_i = x;
    @(posedge clk);
    if (r) begin
      hist  = '0;
      valid = 0;
    end else begin
      hist = {hist[10:0], x};
      if (valid < 12) valid++;
    end
    exp_det = (valid == 12) && (hist == REF_PAT);
    #1;
    cyc++;
    chk("det", {31'd0, det_o}, {31'd0, exp_det});
    chk("b2b", {31'd0, prev_det & det_o}, 32'd0);
    if (det_o === 1'b1) begin
      pulses++;
      if (last_pulse >= 0) last_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
    prev_det = det_o;
  endtask

  // Feed n bits, most significant of the low n bits first
  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) tick(1'b0, bits[i]);
  endtask

  task automatic restart();
    tick(1'b1, 1'b0);
    pulses     = 0;
    last_pulse = -1;
    last_gap   = 0;
  endtask

  initial begin
    logic [11:0] p;
    int          inj;
    n_total    = 0;
    n_pass     = 0;
    cyc        = 0;
    hist       = '0;
    valid      = 0;
    prev_det   = 1'b0;
    pulses     = 0;
    last_pulse = -1;
    last_gap   = 0;
    p          = REF_PAT;

    // 1: reset with x_i high, then one clean pattern
    tick(1'b1, 1'b1);
    chk("reset_det", {31'd0, det_o}, 32'd0);
    pulses = 0;
    feed({20'd0, p}, 12);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("t1_pulses", pulses, 1);

    // 2: overlapping occurrences, 9 cycles apart
    restart();
    feed(32'b111000000111000000111, 21);
    tick(1'b0, 1'b0);
    chk("t2_pulses", pulses, 2);
    chk("t2_gap", last_gap, 9);

    // 3: near misses with 5 and 7 zeros
    restart();
    feed(32'b11100000111, 11);
    tick(1'b0, 1'b0);
    restart();
    feed(32'b1110000000111, 13);
    tick(1'b0, 1'b0);
    chk("t3_pulses", pulses, 0);

    // 4: extra leading ones
    restart();
    feed(32'b11111000000111, 14);
    tick(1'b0, 1'b0);
    chk("t4_pulses", pulses, 1);

    // 5: reset mid-sequence, then a full pattern
    restart();
    feed({24'd0, p[11:4]}, 8);
    tick(1'b1, 1'b1);
    feed({28'd0, p[3:0]}, 4);
    tick(1'b0, 1'b0);
    chk("t5_nopulse", pulses, 0);
    feed({20'd0, p}, 12);
    tick(1'b0, 1'b0);
    chk("t5_pulse", pulses, 1);

    // 6: random stream with occasional injected patterns and rare resets
    restart();
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        tick(1'b1, 1'($urandom));
      end else if ($urandom_range(0, 59) == 0) begin
        inj = $urandom_range(0, 2);
        if (inj == 0)      feed({20'd0, p}, 12);
        else if (inj == 1) feed(32'b111000000111000000111, 21);
        else               feed({21'd0, p[11:1]}, 11);
      end else begin
        tick(1'b0, 1'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
